// File: rtl/csr_access_ctrl_if.sv
// Bundle between dispatch/writeback lanes, csr_access_ctrl and the CSR file ports.
// slave is the controller's view; master is the surrounding pipeline/CSR side.
interface csr_access_ctrl_if #(
  parameter int AW = 14,
  parameter int DW = 32
);

  logic          rd0_req;
  logic          rd1_req;
  logic [AW-1:0] rd0_addr;
  logic [AW-1:0] rd1_addr;
  logic          rd0_gnt;
  logic          rd1_gnt;
  logic          rd0_rvalid;
  logic          rd1_rvalid;
  logic [DW-1:0] rd_rdata;

  logic          csr_read_en;
  logic [AW-1:0] csr_read_addr;
  logic [DW-1:0] csr_read_data;

  logic          wr0_valid;
  logic          wr1_valid;
  logic [AW-1:0] wr0_addr;
  logic [AW-1:0] wr1_addr;
  logic [DW-1:0] wr0_data;
  logic [DW-1:0] wr1_data;
  logic          wr_ready;

  logic          csr_write_en;
  logic [AW-1:0] csr_write_addr;
  logic [DW-1:0] csr_write_data;
  logic          wq_empty;

  modport slave (
    input  rd0_req, rd1_req, rd0_addr, rd1_addr, csr_read_data,
    input  wr0_valid, wr1_valid, wr0_addr, wr1_addr, wr0_data, wr1_data,
    output rd0_gnt, rd1_gnt, rd0_rvalid, rd1_rvalid, rd_rdata,
    output csr_read_en, csr_read_addr, wr_ready,
    output csr_write_en, csr_write_addr, csr_write_data, wq_empty
  );

  modport master (
    output rd0_req, rd1_req, rd0_addr, rd1_addr, csr_read_data,
    output wr0_valid, wr1_valid, wr0_addr, wr1_addr, wr0_data, wr1_data,
    input  rd0_gnt, rd1_gnt, rd0_rvalid, rd1_rvalid, rd_rdata,
    input  csr_read_en, csr_read_addr, wr_ready,
    input  csr_write_en, csr_write_addr, csr_write_data, wq_empty
  );

endinterface

// File: rtl/csr_access_ctrl.sv
// Two-lane CSR read arbiter (round-robin, data 1 cycle after grant) plus in-order dual-enqueue write queue.
// Writes drain one per cycle from the head; wr_ready needs 2 free slots; reads hitting a queued address wait.
module csr_access_ctrl #(
  parameter int QDEPTH = 4,
  parameter int AW     = 14,
  parameter int DW     = 32
) (
  input logic              clk,
  input logic              rst,
  csr_access_ctrl_if.slave bus
);

  localparam int LW = $clog2(QDEPTH);
  localparam int PW = LW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [LW-1:0] idx_t;

  ptr_t              head;
  ptr_t              tail;
  ptr_t              occ;
  ptr_t              free_slots;
  idx_t              tail_idx0;
  idx_t              tail_idx1;
  logic [AW-1:0]     q_addr [QDEPTH];
  logic [DW-1:0]     q_data [QDEPTH];
  logic [QDEPTH-1:0] q_live;
  logic [1:0]        n_wr;
  logic              enq_ok;
  logic              deq;

  logic              blk0;
  logic              blk1;
  logic              cand0;
  logic              cand1;
  logic              contested;
  logic              gnt0;
  logic              gnt1;
  logic              rr;
  logic              rvalid0;
  logic              rvalid1;
  logic [DW-1:0]     rdata;

  assign occ        = tail - head;
  assign free_slots = ptr_t'(QDEPTH) - occ;
  assign deq        = (occ != '0);
  assign n_wr       = {1'b0, bus.wr0_valid} + {1'b0, bus.wr1_valid};
  // A lone write at occupancy QDEPTH-1 still fits; anything that would overflow is dropped whole.
  assign enq_ok     = (ptr_t'(n_wr) <= free_slots);
  assign tail_idx0  = tail[LW-1:0];
  assign tail_idx1  = tail[LW-1:0] + idx_t'(bus.wr0_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (deq) begin
        head <= head + ptr_t'(1);
      end
      if (enq_ok) begin
        tail <= tail + ptr_t'(n_wr);
        if (bus.wr0_valid) begin
          q_addr[tail_idx0] <= bus.wr0_addr;
          q_data[tail_idx0] <= bus.wr0_data;
        end
        if (bus.wr1_valid) begin
          q_addr[tail_idx1] <= bus.wr1_addr;
          q_data[tail_idx1] <= bus.wr1_data;
        end
      end
    end
  end

  // Slot i is live when its distance from head (mod QDEPTH) is below occupancy.
  always_comb begin
    idx_t off;
    off    = '0;
    q_live = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      off       = idx_t'(i) - head[LW-1:0];
      q_live[i] = (ptr_t'(off) < occ);
    end
  end

  always_comb begin
    blk0 = (bus.wr0_valid && (bus.wr0_addr == bus.rd0_addr)) ||
           (bus.wr1_valid && (bus.wr1_addr == bus.rd0_addr));
    blk1 = (bus.wr0_valid && (bus.wr0_addr == bus.rd1_addr)) ||
           (bus.wr1_valid && (bus.wr1_addr == bus.rd1_addr));
    for (int i = 0; i < QDEPTH; i++) begin
      if (q_live[i] && (q_addr[i] == bus.rd0_addr)) begin
        blk0 = 1'b1;
      end
      if (q_live[i] && (q_addr[i] == bus.rd1_addr)) begin
        blk1 = 1'b1;
      end
    end
  end

  assign cand0     = bus.rd0_req && !blk0 && !rst;
  assign cand1     = bus.rd1_req && !blk1 && !rst;
  assign contested = cand0 && cand1;
  assign gnt0      = cand0 && (!cand1 || !rr);
  assign gnt1      = cand1 && (!cand0 || rr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr      <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
    end else begin
      rr      <= rr ^ contested;
      rvalid0 <= gnt0;
      rvalid1 <= gnt1;
      if (gnt0 || gnt1) begin
        rdata <= bus.csr_read_data;
      end
    end
  end

  assign bus.rd0_gnt        = gnt0;
  assign bus.rd1_gnt        = gnt1;
  assign bus.rd0_rvalid     = rvalid0;
  assign bus.rd1_rvalid     = rvalid1;
  assign bus.rd_rdata       = rdata;
  assign bus.csr_read_en    = gnt0 || gnt1;
  assign bus.csr_read_addr  = gnt1 ? bus.rd1_addr : (gnt0 ? bus.rd0_addr : '0);

  assign bus.wr_ready       = (free_slots >= ptr_t'(2));
  assign bus.wq_empty       = !deq;
  assign bus.csr_write_en   = deq;
  assign bus.csr_write_addr = q_addr[head[LW-1:0]];
  assign bus.csr_write_data = q_data[head[LW-1:0]];

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: per-cycle grant/queue reference model with read and write scoreboards,
// driven through directed scenarios (contested reads, dual writes, RAW, full/wrap, occupancy-3, async reset).
module tb_csr_access_ctrl;

  localparam int QD = 4;
  localparam int AW = 14;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csr_access_ctrl_if #(.AW(AW), .DW(DW)) bus ();
  csr_access_ctrl #(.QDEPTH(QD), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DW-1:0] csr_mem [2**AW];
  logic [DW-1:0] ref_mem [2**AW];

  assign bus.csr_read_data = csr_mem[bus.csr_read_addr];
  always @(posedge clk) begin
    if (bus.csr_write_en) csr_mem[bus.csr_write_addr] <= bus.csr_write_data;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    return 32'hC0DE_0000 | DW'(i);
  endfunction

  // ---------------- reference model / scoreboards ----------------
  ent_t          wq[$];
  logic [DW-1:0] rq0[$];
  logic [DW-1:0] rq1[$];
  int            glog[$];
  bit            pend0, pend1, rr_m, pg0, pg1;
  bit            b0, b1, c0, c1, eg0, eg1;
  int            m_occ;
  int            wr_seen = 0;
  ent_t          e;
  logic [DW-1:0] dummy;

  always @(negedge clk) begin
    if (rst) begin
      wq.delete();
      rq0.delete();
      rq1.delete();
      pend0 = 0; pend1 = 0; rr_m = 0; pg0 = 0; pg1 = 0;
    end else begin
      b0 = 0;
      b1 = 0;
      foreach (wq[i]) begin
        if (wq[i].a == bus.rd0_addr) b0 = 1;
        if (wq[i].a == bus.rd1_addr) b1 = 1;
      end
      if (bus.wr0_valid && bus.wr0_addr == bus.rd0_addr) b0 = 1;
      if (bus.wr1_valid && bus.wr1_addr == bus.rd0_addr) b0 = 1;
      if (bus.wr0_valid && bus.wr0_addr == bus.rd1_addr) b1 = 1;
      if (bus.wr1_valid && bus.wr1_addr == bus.rd1_addr) b1 = 1;
      c0  = bus.rd0_req && !b0;
      c1  = bus.rd1_req && !b1;
      eg0 = c0 && (!c1 || !rr_m);
      eg1 = c1 && (!c0 || rr_m);
      if (c0 && c1) rr_m = !rr_m;

      check("gnt0", bus.rd0_gnt, eg0);
      check("gnt1", bus.rd1_gnt, eg1);
      check("rd_en", bus.csr_read_en, eg0 || eg1);
      if (eg0) check("rd_addr0", bus.csr_read_addr, bus.rd0_addr);
      if (eg1) check("rd_addr1", bus.csr_read_addr, bus.rd1_addr);
      check("rv0", bus.rd0_rvalid, pg0);
      check("rv1", bus.rd1_rvalid, pg1);
      if (bus.rd0_rvalid) begin
        if (rq0.size() > 0) check("rdata0", bus.rd_rdata, rq0.pop_front());
        else check("rv0_extra", bus.rd0_rvalid, 0);
      end
      if (bus.rd1_rvalid) begin
        if (rq1.size() > 0) check("rdata1", bus.rd_rdata, rq1.pop_front());
        else check("rv1_extra", bus.rd1_rvalid, 0);
      end

      m_occ = wq.size();
      check("wr_ready", bus.wr_ready, m_occ <= QD - 2);
      check("wq_empty", bus.wq_empty, m_occ == 0);
      check("wr_en", bus.csr_write_en, m_occ > 0);
      if (bus.csr_write_en) begin
        wr_seen++;
        if (wq.size() > 0) begin
          e = wq.pop_front();
          check("wr_addr", bus.csr_write_addr, e.a);
          check("wr_data", bus.csr_write_data, e.d);
        end
      end

      if ((int'(bus.wr0_valid) + int'(bus.wr1_valid)) <= QD - m_occ) begin
        if (bus.wr0_valid) begin
          e.a = bus.wr0_addr; e.d = bus.wr0_data;
          wq.push_back(e);
          ref_mem[bus.wr0_addr] = bus.wr0_data;
        end
        if (bus.wr1_valid) begin
          e.a = bus.wr1_addr; e.d = bus.wr1_data;
          wq.push_back(e);
          ref_mem[bus.wr1_addr] = bus.wr1_data;
        end
      end

      if (pend0 && !bus.rd0_req) begin dummy = rq0.pop_back(); pend0 = 0; end
      if (pend1 && !bus.rd1_req) begin dummy = rq1.pop_back(); pend1 = 0; end
      if (bus.rd0_req && !pend0) begin rq0.push_back(ref_mem[bus.rd0_addr]); pend0 = 1; end
      if (bus.rd1_req && !pend1) begin rq1.push_back(ref_mem[bus.rd1_addr]); pend1 = 1; end
      if (bus.rd0_gnt) begin pend0 = 0; glog.push_back(0); end
      if (bus.rd1_gnt) begin pend1 = 0; glog.push_back(1); end
      pg0 = bus.rd0_gnt;
      pg1 = bus.rd1_gnt;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd0_req   = 1'b0; bus.rd1_req   = 1'b0;
    bus.rd0_addr  = '0;   bus.rd1_addr  = '0;
    bus.wr0_valid = 1'b0; bus.wr1_valid = 1'b0;
    bus.wr0_addr  = '0;   bus.wr1_addr  = '0;
    bus.wr0_data  = '0;   bus.wr1_data  = '0;
  endtask

  task automatic put_wr(input bit v0, input int a0, input int d0, input bit v1, input int a1, input int d1);
    bus.wr0_valid = v0; bus.wr0_addr = AW'(a0); bus.wr0_data = DW'(d0);
    bus.wr1_valid = v1; bus.wr1_addr = AW'(a1); bus.wr1_data = DW'(d1);
  endtask

  task automatic wait_empty(input string tag);
    int k;
    k = 0;
    while (!bus.wq_empty && k < 50) begin
      tick();
      k++;
    end
    check(tag, bus.wq_empty, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt0"}, bus.rd0_gnt, 0);
    check({tag, "_gnt1"}, bus.rd1_gnt, 0);
    check({tag, "_rv0"}, bus.rd0_rvalid, 0);
    check({tag, "_rv1"}, bus.rd1_rvalid, 0);
    check({tag, "_rden"}, bus.csr_read_en, 0);
    check({tag, "_rdaddr"}, bus.csr_read_addr, 0);
    check({tag, "_rdata"}, bus.rd_rdata, 0);
    check({tag, "_wen"}, bus.csr_write_en, 0);
    check({tag, "_waddr"}, bus.csr_write_addr, 0);
    check({tag, "_wdata"}, bus.csr_write_data, 0);
    check({tag, "_empty"}, bus.wq_empty, 1);
    check({tag, "_ready"}, bus.wr_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_g[4];
    int issued, lows, k, snap;
    exp_g = '{0, 1, 0, 1};
    for (int i = 0; i < 2**AW; i++) begin
      csr_mem[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    rst = 1'b1;
    idle_inputs();
    #2;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // contested reads held for 4 cycles
    bus.rd0_req = 1'b1; bus.rd0_addr = AW'(0);
    bus.rd1_req = 1'b1; bus.rd1_addr = AW'(5);
    repeat (4) tick();
    bus.rd0_req = 1'b0; bus.rd1_req = 1'b0;
    repeat (2) tick();
    check("rr_cnt", glog.size(), 4);
    for (int i = 0; i < 4; i++) check("rr_order", (i < glog.size()) ? glog[i] : 99, exp_g[i]);

    // dual writes to one address, program order preserved
    put_wr(1, 'h006, 'hA, 1, 'h006, 'hB);
    tick();
    put_wr(0, 0, 0, 0, 0, 0);
    wait_empty("dual_drain");
    tick();
    check("dual_final", csr_mem[6], 32'hB);

    // RAW: read of an address written in the same cycle waits for the drain
    put_wr(1, 'h00C, 'h1234, 0, 0, 0);
    bus.rd0_req = 1'b1; bus.rd0_addr = AW'('h00C);
    tick();
    put_wr(0, 0, 0, 0, 0, 0);
    k = 1;
    while (1) begin
      @(negedge clk);
      if (bus.rd0_gnt || k >= 20) break;
      tick();
      k++;
    end
    check("raw_lat", k, 2);
    tick();
    bus.rd0_req = 1'b0;
    check("raw_rv", bus.rd0_rvalid, 1);
    check("raw_data", bus.rd_rdata, 32'h1234);
    tick();

    // full / wrap: 12 writes, 2 per accepted cycle
    issued = 0; lows = 0; k = 0;
    while (issued < 12 && k < 60) begin
      if (bus.wr_ready) begin
        put_wr(1, 'h100 + issued, 'hD000_0000 + issued, 1, 'h101 + issued, 'hD000_0001 + issued);
        issued += 2;
      end else begin
        put_wr(0, 0, 0, 0, 0, 0);
        lows++;
      end
      tick();
      k++;
    end
    put_wr(0, 0, 0, 0, 0, 0);
    snap = wr_seen;
    check("wrap_issued", issued, 12);
    check("wrap_rdy_drop", lows > 0, 1);
    wait_empty("wrap_drain");
    check("wrap_left", wq.size(), 0);
    check("wrap_csr_last", csr_mem['h10B], 32'hD000_000B);

    // enqueue + drain at occupancy 3
    put_wr(1, 'h200, 'h20, 1, 'h201, 'h21);
    tick();
    put_wr(1, 'h202, 'h22, 1, 'h203, 'h23);
    tick();
    check("occ3_rdy_a", bus.wr_ready, 0);
    put_wr(1, 'h204, 'h24, 0, 0, 0);
    tick();
    put_wr(0, 0, 0, 0, 0, 0);
    check("occ3_rdy_b", bus.wr_ready, 0);
    check("occ3_empty", bus.wq_empty, 0);
    tick();
    check("occ3_rdy_c", bus.wr_ready, 1);
    wait_empty("occ3_drain");
    tick();
    check("occ3_csr", csr_mem['h204], 32'h24);

    // async reset with 3 writes queued and a response in flight
    put_wr(1, 'h300, 'h30, 1, 'h301, 'h31);
    tick();
    put_wr(1, 'h302, 'h32, 1, 'h303, 'h33);
    bus.rd0_req = 1'b1; bus.rd0_addr = AW'('h3F0);
    tick();
    put_wr(0, 0, 0, 0, 0, 0);
    bus.rd0_req = 1'b0;
    bus.rd1_req = 1'b1; bus.rd1_addr = AW'('h3F1);
    check("pre_rst_rv", bus.rd0_rvalid, 1);
    check("pre_rst_empty", bus.wq_empty, 0);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("arst");
    bus.rd1_req = 1'b0;
    tick();
    rst = 1'b0;
    snap = wr_seen;
    repeat (8) tick();
    check("arst_no_wr", wr_seen - snap, 0);
    check("arst_disc", csr_mem['h303], init_val('h303));

    check("end_rq0", rq0.size(), 0);
    check("end_rq1", rq1.size(), 0);
    check("end_wq", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_access_ctrl.md
# csr_access_ctrl

Access controller in front of the single-port CSR file. It arbitrates two dispatch lanes competing for the one CSR read port and serialises committed CSR writes from two writeback lanes onto the one CSR write port through an in-order write queue. It also blocks reads that would return stale data while a write to the same address is still queued. It sits between dispatch/writeback and `csr`.

## Interface
- `QDEPTH`, 4: write-queue entries; must be a power of two, ≥ 2.
- `AW`, 14: CSR address width.
- `DW`, 32: CSR data width.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rd0_req`, `rd1_req` in 1: read request from dispatch lane 0 / lane 1.
- `rd0_addr`, `rd1_addr` in AW: read address for each lane.
- `rd0_gnt`, `rd1_gnt` out 1: combinational grant for each lane.
- `rd0_rvalid`, `rd1_rvalid` out 1: read response valid, one cycle after the grant.
- `rd_rdata` out DW: registered read data; shared by both lanes, since only one lane is valid at a time.
- `csr_read_en` out 1, `csr_read_addr` out AW: CSR read port.
- `csr_read_data` in DW: CSR read data; combinational in the same cycle as the address.
- `wr0_valid`, `wr1_valid` in 1: committed write from wb lane 0 / lane 1. Lane 0 is older in program order.
- `wr0_addr`, `wr1_addr` in AW; `wr0_data`, `wr1_data` in DW: write address and data per lane.
- `wr_ready` out 1: high when at least 2 queue entries are free.
- `csr_write_en` out 1, `csr_write_addr` out AW, `csr_write_data` out DW: CSR write port.
- `wq_empty` out 1: queue empty. Used by ertn/exception logic to wait for drain.

## Operation
- Write queue: circular FIFO with `QDEPTH` entries; head/tail pointers are log2(QDEPTH)+1 bits wide.
- Enqueue: only valid lanes are written. Lane 0 goes to `tail`; lane 1 goes to `tail` if lane 0 is idle, otherwise to `tail+1`. Tail advances by the number of valid lanes.
- Writebackers must not assert `wrX_valid` while `wr_ready`=0. A write presented while `wr_ready`=0 is a protocol violation; the queue contents stay unchanged (the write is dropped).
- Drain: when the queue is non-empty, the head entry drives the `csr_write_*` port with `csr_write_en`=1, and head advances. This is one write per cycle, in strict program order.
- Read hazard: lane X is *blocked* when `rdX_addr` matches the address of any valid queue entry, or `wrY_addr` of any valid write lane in the same cycle.
- Arbitration: among unblocked requesters, exactly one is granted per cycle.
  - Single requester: it wins.
  - Both requesting: the lane named by the round-robin pointer `rr` wins. `rr` resets to 0 and flips to the other lane after a contested grant.
  - Uncontested grants leave `rr` unchanged.
- Granted lane drives `csr_read_en`=1 and `csr_read_addr`. `csr_read_data` is captured into `rd_rdata`, and that lane's `rdX_rvalid` is set for exactly one cycle.
- Ungranted requesters must hold address and request.

## Timing
- Reset values:
  - All `*_gnt`, `*_rvalid`, `csr_read_en` and `csr_write_en` are 0.
  - `rd_rdata`, `csr_*_addr` and `csr_write_data` are 0.
  - `wq_empty`=1, `wr_ready`=1, `rr`=0, and head = tail = 0.
- Asserting `rst` mid-operation discards all queued writes and any in-flight response immediately, without waiting for a clock edge.
- Read latency: grant in cycle N; `rdX_rvalid` and `rd_rdata` valid in cycle N+1.
- Write latency: a write enqueued in cycle N appears on `csr_write_*` no earlier than cycle N+1. An empty queue with 2 writes: lane 0's write in N+1, lane 1's write in N+2.
- `csr_write_*` are registered from the head entry. `csr_write_en` is 0 whenever the queue is empty.
- Enqueue and drain may occur in the same cycle. Occupancy changes by (enqueued − 1).
- Full: occupancy = QDEPTH, so `wr_ready`=0. `wr_ready` reflects occupancy at the start of the cycle.
- Wrap-around: pointer MSB distinguishes full from empty; addresses index with the low bits.
- A blocked read is released the cycle after the last matching entry drains.

## Test plan
- Reset: assert `rst` asynchronously with 3 writes queued → all outputs at reset values in the same cycle; after release, no `csr_write_en` pulse ever appears for the discarded writes.
- Contested reads: `rd0_req`=`rd1_req`=1, addresses 0x000 and 0x005, held for 4 cycles → grant order is lane 0, 1, 0, 1; each `rvalid` follows its grant by one cycle, with `rd_rdata` equal to the CSR model value.
- Dual writes: `wr0`=(0x006, 0xA), `wr1`=(0x006, 0xB) in the same cycle → two write-port cycles, 0xA then 0xB; the final CSR value is 0xB.
- RAW block: queue a write to 0x00C=0x1234 and present `rd0` for 0x00C in the same cycle → no grant until the write drains; the read then returns 0x1234.
- Full/wrap: `QDEPTH`=4, issue 2 writes per cycle for 6 cycles while honouring `wr_ready` → `wr_ready` drops once occupancy > 2; all 12 writes appear on the port in order, with no loss or duplication across pointer wrap.
- Simultaneous enqueue + drain at occupancy 3 with one write → occupancy stays 3 and `wr_ready` stays 0.
